gate_stim_checker: RTL
======================

// Module: gate_stim_checker
// PURPOSE
//   Self-running stimulus/check stage wrapped around a 2-input universal gate (univ_nand style: a, b -> out).
//   Drives gate_a/gate_b through all four input vectors, in the order the NAND bench toggles them:
//   a toggles fastest. Samples gate_out after a settle window and compares it to the expected truth table.
//   Counts mismatches and reports pass/fail with a start/done handshake. Replaces free-running bench stimulus.
// PARAMETERS
//   SETTLE      2   cycles gate_a/gate_b are held before gate_out is sampled (legal >=1)
//   NUM_PASSES  1   full 4-vector sweeps per run (legal 1..255)
//   ERR_W       8   width of err_cnt; the counter saturates at all-ones
// PORTS
//   clk         in   1      rising-edge clock
//   rst_n       in   1      asynchronous active-low reset
//   start       in   1      1-cycle request; honoured only in IDLE
//   abort       in   1      synchronous abort; forces IDLE from any state
//   gate_out    in   1      output of the gate under test
//   gate_a      out  1      gate input a (= vec[0])
//   gate_b      out  1      gate input b (= vec[1])
//   busy        out  1      high in DRIVE/SAMPLE
//   done        out  1      1-cycle pulse at end of run
//   pass        out  1      valid from done until next start; 1 iff err_cnt==0
//   err_cnt     out  ERR_W  mismatch count, saturating
//   fail_valid  out  1      a mismatch has been captured this run
//   fail_vec    out  2      {b,a} of first mismatch
// BEHAVIOUR
//   Reset (rst_n=0, async): state=IDLE; all outputs 0, including gate_a, gate_b, err_cnt and fail_vec.
//   FSM states: IDLE, DRIVE, SAMPLE, DONE.
//   IDLE:   start=1 -> DRIVE, with vec=0, pass_cnt=0, settle_cnt=0.
//           The same edge clears err_cnt, fail_valid, fail_vec and pass.
//   DRIVE:  {gate_b,gate_a}=vec is registered. After SETTLE cycles in DRIVE -> SAMPLE.
//   SAMPLE: one cycle. gate_out is compared with exp = ~(gate_a & gate_b).
//           - On mismatch: err_cnt++ (saturating). If fail_valid==0, set fail_valid=1 and fail_vec=vec.
//           - If vec==3 and pass_cnt==NUM_PASSES-1 -> DONE.
//           - Otherwise vec wraps 3->0, pass_cnt++ on wrap, next state DRIVE.
//   DONE:   done=1 for exactly one cycle; pass=(err_cnt==0); gate_a=gate_b=0; next state IDLE.
//   Latency: done is high exactly NUM_PASSES*4*(SETTLE+1)+1 cycles after the start-sampling edge.
//            Defaults give 13.
//   start in any non-IDLE state is ignored; it neither restarts nor queues.
//   abort has priority over start and every transition:
//            next state IDLE, gate_a=gate_b=0, no done pulse, pass=0.
//            err_cnt/fail_* keep their last values.
//   An err_cnt increment and a simultaneous abort: abort wins, no increment.
//   rst_n low mid-run: immediate return to the reset values above.
//   gate_out is sampled directly; the gate under test must settle within SETTLE cycles.
// CONFIGURATION
//   GATE_SEL_EN defined: adds input port func_sel[1:0], latched on the accepted start.
//       Expected value: 00 ~(a&b) NAND; 01 ~(a|b) NOR; 10 a&b; 11 a|b.
//       func_sel changes during a run have no effect.
//   GATE_SEL_EN undefined: no func_sel port; expected value is fixed at NAND.
// TESTING
//   1 Correct NAND model, defaults, start pulse ->
//     a/b sequence 00,10,01,11 ({b,a}=0,1,2,3); done at cycle 13; pass=1; err_cnt=0; fail_valid=0.
//   2 gate_out stuck at 1 ->
//     one mismatch at vec=3; err_cnt=1; fail_vec=2'b11; fail_valid=1; pass=0.
//   3 NUM_PASSES=3, SETTLE=1, gate_out stuck at 0 ->
//     err_cnt=9; fail_vec=0; done 25 cycles after start.
//   4 abort during SAMPLE of vec=2 ->
//     IDLE next cycle; gate_a=gate_b=0; no done; later start runs cleanly with err_cnt reset to 0.
//   5 ERR_W=2, stuck-at-0 gate, NUM_PASSES=2 -> err_cnt saturates at 3.
//     start pulses while busy are ignored: same done time as a single run.
//   6 GATE_SEL_EN, func_sel=01, NOR model -> pass=1.
//     Same run with a NAND model -> err_cnt=2, fail_vec=2'b01.
//     rst_n pulsed mid-run clears all outputs asynchronously.

Source files
------------

// File: rtl/gate_stim_checker.sv
// rtl/gate_stim_checker.sv - self-running stimulus/check stage for a 2-input gate under test
//
// Sweeps {gate_b,gate_a} through 0,1,2,3 (a toggles fastest), holds each vector
// for SETTLE cycles, then spends one SAMPLE cycle comparing gate_out with the
// expected truth table. Repeats for NUM_PASSES sweeps, then pulses done.
//
// Optional feature macro: GATE_SEL_EN
//   defined   : adds func_sel[1:0], latched on the accepted start
//               (00 NAND, 01 NOR, 10 AND, 11 OR)
//   undefined : expected function fixed at NAND
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   start      in   1-cycle run request, honoured only in IDLE
//   abort      in   synchronous abort to IDLE from any state
//   func_sel   in   expected-function select (GATE_SEL_EN only)
//   gate_out   in   output of the gate under test
//   gate_a     out  gate input a (vec[0])
//   gate_b     out  gate input b (vec[1])
//   busy       out  high while driving/sampling
//   done       out  1-cycle pulse at end of a completed run
//   pass       out  1 iff err_cnt==0, valid from done until next start
//   err_cnt    out  saturating mismatch count
//   fail_valid out  a mismatch has been captured this run
//   fail_vec   out  {b,a} of the first mismatch
module gate_stim_checker #(
   parameter int SETTLE     = 2,
   parameter int NUM_PASSES = 1,
   parameter int ERR_W      = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             abort,
`ifdef GATE_SEL_EN
   input  logic [1:0]       func_sel,
`endif
   input  logic             gate_out,
   output logic             gate_a,
   output logic             gate_b,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [ERR_W-1:0] err_cnt,
   output logic             fail_valid,
   output logic [1:0]       fail_vec
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DRIVE  = 2'd1,
      ST_SAMPLE = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   localparam int               CNT_W       = 16;
   localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE - 1);
   localparam logic [7:0]       PASS_LAST   = 8'(NUM_PASSES - 1);

   state_t           state;
   state_t           state_nxt;
   logic [1:0]       vec;
   logic [CNT_W-1:0] settle_cnt;
   logic [7:0]       pass_cnt;
   logic             exp_out;
   logic             mismatch;
   logic             last_vec;

   // The applied vector is the registered vec itself, so gate_a/gate_b
   // return to 0 whenever vec is cleared (reset, abort, end of run).
   assign gate_a = vec[0];
   assign gate_b = vec[1];
   assign busy   = (state == ST_DRIVE) || (state == ST_SAMPLE);

`ifdef GATE_SEL_EN
   logic [1:0] sel_q;

   always_comb begin
      exp_out = 1'b0;
      case (sel_q)
         2'b00:   exp_out = ~(gate_a & gate_b);
         2'b01:   exp_out = ~(gate_a | gate_b);
         2'b10:   exp_out = gate_a & gate_b;
         default: exp_out = gate_a | gate_b;
      endcase
   end
`else
   assign exp_out = ~(gate_a & gate_b);
`endif

   // abort suppresses the compare so a coincident mismatch is not counted
   assign mismatch = (state == ST_SAMPLE) && (gate_out != exp_out) && !abort;
   assign last_vec = (vec == 2'd3) && (pass_cnt == PASS_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:   if (start) state_nxt = ST_DRIVE;
         ST_DRIVE:  if (settle_cnt == SETTLE_LAST) state_nxt = ST_SAMPLE;
         ST_SAMPLE: state_nxt = last_vec ? ST_DONE : ST_DRIVE;
         ST_DONE:   state_nxt = ST_IDLE;
         default:   state_nxt = ST_IDLE;
      endcase
      if (abort) begin
         state_nxt = ST_IDLE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vec        <= 2'd0;
         settle_cnt <= '0;
         pass_cnt   <= 8'd0;
         done       <= 1'b0;
         pass       <= 1'b0;
         err_cnt    <= '0;
         fail_valid <= 1'b0;
         fail_vec   <= 2'd0;
`ifdef GATE_SEL_EN
         sel_q      <= 2'b00;
`endif
      end else begin
         done <= 1'b0;
         if (abort) begin
            // results of the aborted run stay visible; only pass is withdrawn
            vec        <= 2'd0;
            settle_cnt <= '0;
            pass_cnt   <= 8'd0;
            pass       <= 1'b0;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (start) begin
                     vec        <= 2'd0;
                     settle_cnt <= '0;
                     pass_cnt   <= 8'd0;
                     pass       <= 1'b0;
                     err_cnt    <= '0;
                     fail_valid <= 1'b0;
                     fail_vec   <= 2'd0;
`ifdef GATE_SEL_EN
                     sel_q      <= func_sel;
`endif
                  end
               end
               ST_DRIVE: begin
                  if (settle_cnt != SETTLE_LAST) begin
                     settle_cnt <= settle_cnt + CNT_W'(1);
                  end
               end
               ST_SAMPLE: begin
                  settle_cnt <= '0;
                  if (mismatch) begin
                     if (err_cnt != '1) begin
                        err_cnt <= err_cnt + ERR_W'(1);
                     end
                     if (!fail_valid) begin
                        fail_valid <= 1'b1;
                        fail_vec   <= vec;
                     end
                  end
                  if (last_vec) begin
                     vec <= 2'd0;
                  end else begin
                     vec <= vec + 2'd1;
                     if (vec == 2'd3) begin
                        pass_cnt <= pass_cnt + 8'd1;
                     end
                  end
               end
               ST_DONE: begin
                  done <= 1'b1;
                  pass <= (err_cnt == '0);
               end
               default: ;
            endcase
         end
      end
   end

endmodule
